store_packer: RTL and testbench

STORE_PACKER -- requirements
Module: store_packer

---
 rtl/store_packer_pkg.sv | 31 +++
 rtl/store_merge.sv | 35 +++
 rtl/store_packer.sv | 100 ++++++++++
 tb/tb_store_packer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_packer_pkg.sv
// Shared store encodings, FSM states and the alignment rule used by the store
// packer and the core decoder.
package store_packer_pkg;

   typedef enum logic [1:0] {
      OP_SW   = 2'b00,
      OP_SH   = 2'b01,
      OP_SB   = 2'b10,
      OP_RSVD = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RD    = 2'b01,
      S_MERGE = 2'b10,
      S_WR    = 2'b11
   } state_t;

   // A request is rejected when its address does not suit its size, or the op is reserved.
   function automatic logic misaligned(input op_t op, input logic [1:0] offset);
      logic bad;
      case (op)
         OP_SW:   bad = (offset != 2'b00);
         OP_SH:   bad = offset[0];
         OP_SB:   bad = 1'b0;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational byte/half-word merge of new store data into a word read from memory.
// Little-endian lanes: byte k sits at bits [8k+7:8k].
module store_merge
   import store_packer_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [15:0] data,
   input  op_t         op,
   input  logic [1:0]  offset,
   output logic [31:0] merged
);

   always_comb begin
      merged = old_word;
      case (op)
         OP_SB: begin
            case (offset)
               2'd0: merged[7:0]   = data[7:0];
               2'd1: merged[15:8]  = data[7:0];
               2'd2: merged[23:16] = data[7:0];
               2'd3: merged[31:24] = data[7:0];
               default: merged = old_word;
            endcase
         end
         OP_SH: begin
            if (offset[1])
               merged[31:16] = data;
            else
               merged[15:0] = data;
         end
         default: merged = old_word;
      endcase
   end

endmodule

// File: rtl/store_packer.sv
// Turns sw/sh/sb stores into full-word memory writes; sub-word stores use a
// read-modify-write through RD -> MERGE -> WR.
module store_packer
   import store_packer_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [1:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   input  logic [31:0]       mem_rdata,
   output logic              mem_we,
   output logic [31:0]       mem_wdata
);

   state_t      state;
   op_t         op_q;
   logic [1:0]  offset_q;
   logic [15:0] wdata_q;
   logic [31:0] merged;

   store_merge u_merge (
      .old_word (mem_rdata),
      .data     (wdata_q),
      .op       (op_q),
      .offset   (offset_q),
      .merged   (merged)
   );

   // WR behaves like IDLE for acceptance so a new store can start in the write cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         op_q      <= OP_SW;
         offset_q  <= '0;
         wdata_q   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         done      <= 1'b0;
         err       <= 1'b0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         case (state)
            S_IDLE, S_WR: begin
               state    <= S_IDLE;
               busy     <= 1'b0;
               mem_addr <= '0;
               if (req) begin
                  op_q     <= op_t'(op);
                  offset_q <= addr[1:0];
                  wdata_q  <= wdata[15:0];
                  if (misaligned(op_t'(op), addr[1:0])) begin
                     done <= 1'b1;
                     err  <= 1'b1;
                  end else if (op_t'(op) == OP_SW) begin
                     state     <= S_WR;
                     mem_we    <= 1'b1;
                     mem_wdata <= wdata;
                     mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                     done      <= 1'b1;
                  end else begin
                     state    <= S_RD;
                     mem_re   <= 1'b1;
                     busy     <= 1'b1;
                     mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                  end
               end
            end
            S_RD: begin
               state <= S_MERGE;
               busy  <= 1'b1;
            end
            S_MERGE: begin
               state     <= S_WR;
               busy      <= 1'b0;
               mem_we    <= 1'b1;
               mem_wdata <= merged;
               done      <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_store_packer.sv
// Scoreboard bench for store_packer: directed stores push expected completions,
// a negedge monitor pops and compares them whenever done is seen.
module tb_store_packer;

   logic        clk;
   logic        reset;
   logic        req;
   logic [1:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] mem_addr;
   logic        mem_re;
   logic [31:0] mem_rdata;
   logic        mem_we;
   logic [31:0] mem_wdata;

   typedef struct {
      string       name;
      logic        err;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          checks;
   int          errors;
   logic        monitor_on;
   logic [31:0] mem [16];
   logic        pl_en;
   logic [31:0] pl_addr;
   logic [31:0] pl_val;

   store_packer #(.ADDR_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .op        (op),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] idx(input logic [31:0] a);
      return {a[13:12], a[3:2]};
   endfunction

   // Word memory with one-cycle read latency and a preload port for the stimulus.
   always @(posedge clk) begin
      if (pl_en) mem[idx(pl_addr)] <= pl_val;
      if (mem_we) mem[idx(mem_addr)] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[idx(mem_addr)];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
      end
   endtask

   task automatic pushExp(input string name, input logic e, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
      exp_t x;
      x.name = name;
      x.err  = e;
      x.we   = w;
      x.addr = a;
      x.data = d;
      exp_q.push_back(x);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
      req   = 1'b1;
      op    = o;
      addr  = a;
      wdata = d;
      nextCycle();
      req   = 1'b0;
      op    = 2'b11;
      addr  = 32'hFFFF_FFFF;
      wdata = 32'hFFFF_FFFF;
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] v);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_val  = v;
      nextCycle();
      pl_en   = 1'b0;
   endtask

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, "_busy"}, {31'b0, busy}, 32'h0);
      checkOutput({tag, "_done"}, {31'b0, done}, 32'h0);
      checkOutput({tag, "_err"}, {31'b0, err}, 32'h0);
      checkOutput({tag, "_re"}, {31'b0, mem_re}, 32'h0);
      checkOutput({tag, "_we"}, {31'b0, mem_we}, 32'h0);
      checkOutput({tag, "_addr"}, mem_addr, 32'h0);
      checkOutput({tag, "_wdata"}, mem_wdata, 32'h0);
   endtask

   // Monitor: pops one expectation per done pulse and checks the bus invariants each cycle.
   always @(negedge clk) begin
      if (monitor_on) begin
         checkOutput("re_we_exclusive", {31'b0, mem_re & mem_we}, 32'h0);
         checkOutput("we_only_with_done", {31'b0, mem_we & ~done}, 32'h0);
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_done: got done=1 err=%0b we=%0b addr=0x%08h expected no completion",
                        err, mem_we, mem_addr);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               checkOutput({e.name, "_err"}, {31'b0, err}, {31'b0, e.err});
               checkOutput({e.name, "_we"}, {31'b0, mem_we}, {31'b0, e.we});
               checkOutput({e.name, "_re"}, {31'b0, mem_re}, 32'h0);
               if (e.we) begin
                  checkOutput({e.name, "_addr"}, mem_addr, e.addr);
                  checkOutput({e.name, "_wdata"}, mem_wdata, e.data);
               end
            end
         end else begin
            checkOutput("err_without_done", {31'b0, err}, 32'h0);
         end
      end
   end

   initial begin
      checks     = 0;
      errors     = 0;
      monitor_on = 1'b0;
      reset      = 1'b1;
      req        = 1'b0;
      op         = 2'b00;
      addr       = 32'h0;
      wdata      = 32'h0;
      pl_en      = 1'b0;
      pl_addr    = 32'h0;
      pl_val     = 32'h0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkIdleZero("reset");
      @(posedge clk);
      #1;
      reset      = 1'b0;
      monitor_on = 1'b1;

      // Aligned sw completes one cycle after acceptance with no read.
      pushExp("sw", 1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
      applyStimulus(2'b00, 32'h0000_1000, 32'hDEAD_BEEF);
      @(negedge clk);
      checkOutput("sw_busy", {31'b0, busy}, 32'h0);
      checkOutput("sw_done_at_plus1", {31'b0, done}, 32'h1);
      nextCycle();

      // sb to byte 3
      preload(32'h0000_2000, 32'h1122_3344);
      pushExp("sb_lane3", 1'b0, 1'b1, 32'h0000_2000, 32'hAB22_3344);
      applyStimulus(2'b10, 32'h0000_2003, 32'h0000_00AB);
      @(negedge clk);
      checkOutput("sb_rd_re", {31'b0, mem_re}, 32'h1);
      checkOutput("sb_rd_busy", {31'b0, busy}, 32'h1);
      checkOutput("sb_rd_addr", mem_addr, 32'h0000_2000);
      nextCycle();
      @(negedge clk);
      checkOutput("sb_merge_busy", {31'b0, busy}, 32'h1);
      checkOutput("sb_merge_re", {31'b0, mem_re}, 32'h0);
      nextCycle();
      @(negedge clk);
      checkOutput("sb_wr_busy", {31'b0, busy}, 32'h0);
      checkOutput("sb_wr_done", {31'b0, done}, 32'h1);
      nextCycle();
      @(negedge clk);
      checkOutput("idle_addr_zero", mem_addr, 32'h0);
      nextCycle();

      // sh upper and lower halves
      preload(32'h0000_2000, 32'h1122_3344);
      pushExp("sh_upper", 1'b0, 1'b1, 32'h0000_2000, 32'hCAFE_3344);
      applyStimulus(2'b01, 32'h0000_2002, 32'h0000_CAFE);
      repeat (3) nextCycle();
      preload(32'h0000_2000, 32'h1122_3344);
      pushExp("sh_lower", 1'b0, 1'b1, 32'h0000_2000, 32'h1122_CAFE);
      applyStimulus(2'b01, 32'h0000_2000, 32'h0000_CAFE);
      repeat (3) nextCycle();

      // Rejected requests: misaligned sw, misaligned sh, reserved op
      pushExp("rej_sw", 1'b1, 1'b0, 32'h0, 32'h0);
      applyStimulus(2'b00, 32'h0000_1002, 32'h1234_5678);
      @(negedge clk);
      checkOutput("rej_sw_re", {31'b0, mem_re}, 32'h0);
      checkOutput("rej_sw_busy", {31'b0, busy}, 32'h0);
      nextCycle();
      pushExp("rej_sh", 1'b1, 1'b0, 32'h0, 32'h0);
      applyStimulus(2'b01, 32'h0000_2001, 32'h0000_BEEF);
      nextCycle();
      pushExp("rej_rsvd", 1'b1, 1'b0, 32'h0, 32'h0);
      applyStimulus(2'b11, 32'h0000_1000, 32'h1234_5678);
      @(negedge clk);
      checkOutput("rej_rsvd_re", {31'b0, mem_re}, 32'h0);
      nextCycle();

      // Reset in the MERGE cycle discards the store.
      applyStimulus(2'b10, 32'h0000_2001, 32'h0000_0077);
      nextCycle();
      reset = 1'b1;
      nextCycle();
      reset = 1'b0;
      @(negedge clk);
      checkIdleZero("midop_reset");
      repeat (3) nextCycle();
      checkOutput("midop_mem_intact", mem[idx(32'h0000_2000)], 32'h1122_CAFE);

      // Reset wins over a simultaneous request.
      reset = 1'b1;
      req   = 1'b1;
      op    = 2'b00;
      addr  = 32'h0000_1000;
      wdata = 32'h5555_AAAA;
      nextCycle();
      reset = 1'b0;
      req   = 1'b0;
      @(negedge clk);
      checkIdleZero("reset_priority");
      nextCycle();

      // Back-to-back sb to one word; a req while busy must be dropped.
      preload(32'h0000_3000, 32'h5566_7788);
      pushExp("b2b_first", 1'b0, 1'b1, 32'h0000_3000, 32'h5566_7711);
      applyStimulus(2'b10, 32'h0000_3000, 32'h0000_0011);
      req   = 1'b1;
      op    = 2'b10;
      addr  = 32'h0000_1001;
      wdata = 32'h0000_0099;
      nextCycle();
      nextCycle();
      pushExp("b2b_second", 1'b0, 1'b1, 32'h0000_3000, 32'h5566_2211);
      applyStimulus(2'b10, 32'h0000_3001, 32'h0000_0022);
      repeat (3) nextCycle();
      @(negedge clk);
      checkOutput("b2b_final_word", mem[idx(32'h0000_3000)], 32'h5566_2211);
      repeat (3) nextCycle();

      checkOutput("scoreboard_drained", exp_q.size(), 32'h0);
      monitor_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
